sprite_line_sched: RTL

// - Per-scanline sprite scheduler between the 4-bank sprite attribute shadow RAM (y, attr, x, id) and the sprite line-buffer drawer.
// - On each line_start, scans all NSPR entries in index order and tests each for vertical visibility on line_y.
// - Queues hits in a small FIFO and hands them to the drawer over a valid/ready interface, which decouples attribute scanning from pixel drawing.

---
 rtl/sprite_line_sched_pkg.sv | 23 ++
 rtl/sprite_line_sched_if.sv | 16 +
 rtl/sprite_line_sched_fifo.sv | 38 +++
 rtl/sprite_line_sched.sv | 100 ++++++++++
 4 files changed

// File: rtl/sprite_line_sched_pkg.sv
// sprite_line_sched_pkg: shared constants, attribute/request layouts and scheduler states
package sprite_pkg;
    localparam int NSPR = 128;
    localparam int AW = $clog2(NSPR);
    localparam int FIFO_DEPTH = 16;
    localparam int MAX_PER_LINE = 24;
    localparam logic [8:0] SPR_H_SHORT = 9'd16;
    localparam logic [8:0] SPR_H_TALL = 9'd32;
    typedef struct packed {
        logic [2:0] code_hi;
        logic       tall;
        logic       colour_hi;
        logic       hflip_n;
        logic [1:0] colour_lo;
    } attr_t;
    typedef struct packed {
        logic [4:0] yoff;
        attr_t      attr;
        logic [7:0] x;
        logic [7:0] id;
    } req_t;
    typedef enum logic [1:0] {IDLE, ADDR, EVAL} state_t;
endpackage

// File: rtl/sprite_line_sched_if.sv
// sprite_line_sched_if: shadow-RAM read port plus drawer request handshake
interface sprite_line_sched_if;
    logic [sprite_pkg::AW-1:0] attr_addr;
    logic [7:0] attr_y, attr_a, attr_x, attr_id;
    logic req_valid, req_ready;
    logic [4:0] req_yoff;
    logic [7:0] req_attr, req_x, req_id;
    modport master(
        output attr_addr, input attr_y, attr_a, attr_x, attr_id,
        output req_valid, input req_ready, output req_yoff, req_attr, req_x, req_id
    );
    modport slave(
        input attr_addr, output attr_y, attr_a, attr_x, attr_id,
        input req_valid, output req_ready, input req_yoff, req_attr, req_x, req_id
    );
endinterface

// File: rtl/sprite_line_sched_fifo.sv
// sprite_req_fifo: synchronous show-ahead FIFO with flush; head reads as zero when empty
module sprite_req_fifo #(
    parameter int W = 29,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic empty, do_push, do_pop;
    assign empty = wr_q == rd_q;
    assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop = pop_i & ~empty;
    assign valid_o = ~empty;
    assign dout_o = empty ? '0 : mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/sprite_line_sched.sv
// sprite_line_sched: scans all sprite attributes each line and queues the vertically visible ones
module sprite_line_sched
    import sprite_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int MAX_HITS = MAX_PER_LINE
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                line_start,
    input  logic [8:0]          line_y,
    input  logic                dma_busy,
    sprite_line_sched_if.master bus,
    output logic                scan_done,
    output logic                overflow,
    output logic                busy
);
    localparam int CW = $clog2(MAX_HITS + 1);
    state_t state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0] line_q, line_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic ovf_q, ovf_d;
    logic [8:0] diff, height;
    attr_t attr;
    req_t req_in, head;
    logic hit, room, full, start, abort, stall, push, last, unused_line;
    assign attr = attr_t'(bus.attr_a);
    // 9-bit subtract: a borrow means the sprite starts below this line, never wrapping past 0
    assign diff = {1'b0, line_q} - {1'b0, bus.attr_y};
    assign height = attr.tall ? SPR_H_TALL : SPR_H_SHORT;
    assign hit = ~diff[8] & (diff < height);
    assign room = cnt_q != CW'(MAX_HITS);
    assign start = line_start & ~dma_busy;
    assign abort = dma_busy & (state_q != IDLE);
    assign last = idx_q == AW'(NSPR - 1);
    assign stall = (state_q == EVAL) & hit & room & full;
    assign push = (state_q == EVAL) & hit & room & ~full;
    assign req_in = '{yoff: diff[4:0], attr: attr, x: bus.attr_x, id: bus.attr_id};
    assign unused_line = line_y[8];
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        line_d = line_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        scan_done = 1'b0;
        if (abort) begin
            state_d = IDLE;
            idx_d = '0;
        end else if (start) begin
            state_d = ADDR;
            idx_d = '0;
            line_d = line_y[7:0];
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (state_q == ADDR) begin
            state_d = EVAL;
        end else if (state_q == EVAL && !stall) begin
            cnt_d = cnt_q + CW'(hit & room);
            ovf_d = ovf_q | (hit & ~room);
            scan_done = last;
            state_d = last ? IDLE : ADDR;
            idx_d = last ? '0 : idx_q + AW'(1);
        end
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            line_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            line_q <= line_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
    sprite_req_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
        .clk(clk_sys),
        .rst(reset),
        .flush_i(start | abort),
        .push_i(push),
        .din_i(req_in),
        .pop_i(bus.req_ready),
        .dout_o(head),
        .valid_o(bus.req_valid),
        .full_o(full)
    );
    assign bus.attr_addr = idx_q;
    assign bus.req_yoff = head.yoff;
    assign bus.req_attr = head.attr;
    assign bus.req_x = head.x;
    assign bus.req_id = head.id;
    assign overflow = ovf_q;
    assign busy = (state_q != IDLE) | bus.req_valid;
endmodule
